// File: rtl/wb_trace_capture_if.sv
// Writeback trace input and byte-stream output bundle.
// master drives trace + out_ready; slave drives out_data/out_valid.
interface wb_trace_capture_if;
  logic        wb_en;
  logic [23:0] PC;
  logic [23:0] WBRegData;
  logic [3:0]  WBReg;
  logic        branchControl;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output wb_en, PC, WBRegData, WBReg, branchControl, out_ready,
    input  out_data, out_valid
  );

  modport slave (
    input  wb_en, PC, WBRegData, WBReg, branchControl, out_ready,
    output out_data, out_valid
  );
endinterface

// File: rtl/wb_trace_capture.sv
// Writeback trace capture: record FIFO + byte serializer.
// Ports: clk, reset (sync high), tr (slave: trace in, byte stream out),
// fifo_level, dropped (saturating), busy. Option: TRACE_TIMESTAMP_EN.
module wb_trace_capture #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  wb_trace_capture_if.slave        tr,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]         dropped,
  output logic                     busy
);

  localparam int AW = $clog2(DEPTH);
`ifdef TRACE_TIMESTAMP_EN
  localparam int   NB  = 9;
  localparam logic TSF = 1'b1;
`else
  localparam int   NB  = 7;
  localparam logic TSF = 1'b0;
`endif
  localparam int FW = NB * 8;
  localparam int IW = $clog2(NB);
  localparam logic [IW-1:0] LAST  = IW'(NB - 1);
  localparam logic [AW:0]   FULLV = (AW + 1)'(DEPTH);

  typedef enum logic {IDLE, SEND} state_t;

  // record: {branch, reg[3:0], pc[23:0], data[23:0]}
  logic [52:0]   mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   level;
  logic          empty;
  logic          full;
  logic          fire;
  logic          last;
  logic          pop;
  logic          push;
  logic [52:0]   head;
  logic [FW-1:0] frame;
  logic [FW-1:0] sreg;
  logic [IW-1:0] idx;
  state_t        state;

`ifdef TRACE_TIMESTAMP_EN
  logic [15:0] ts_cnt;
  logic [15:0] ts_mem [DEPTH];
`endif

  assign level = wr_ptr - rd_ptr;
  assign empty = (level == '0);
  assign full  = (level == FULLV);
  assign fire  = tr.out_valid & tr.out_ready;
  assign last  = (idx == LAST);
  // Refill the shifter when idle, or straight after the final byte.
  assign pop   = !empty & ((state == IDLE) | (fire & last));
  // A full FIFO still takes a record if a slot frees this cycle.
  assign push  = tr.wb_en & (!full | pop);
  assign head  = mem[rd_ptr[AW-1:0]];

`ifdef TRACE_TIMESTAMP_EN
  assign frame = {1'b1, head[52], TSF, 1'b0, head[51:0],
                  ts_mem[rd_ptr[AW-1:0]]};
`else
  assign frame = {1'b1, head[52], TSF, 1'b0, head[51:0]};
`endif

  assign fifo_level = level;
  assign busy       = (state == SEND) | !empty;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {tr.branchControl, tr.WBReg,
                              tr.PC, tr.WBRegData};
`ifdef TRACE_TIMESTAMP_EN
      ts_mem[wr_ptr[AW-1:0]] <= ts_cnt;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      dropped      <= '0;
      state        <= IDLE;
      idx          <= '0;
      sreg         <= '0;
      tr.out_data  <= '0;
      tr.out_valid <= 1'b0;
`ifdef TRACE_TIMESTAMP_EN
      ts_cnt       <= '0;
`endif
    end else begin
`ifdef TRACE_TIMESTAMP_EN
      ts_cnt <= ts_cnt + 16'd1;
`endif
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (tr.wb_en && !push && dropped != '1)
        dropped <= dropped + 1'b1;

      unique case (state)
        IDLE: begin
          if (pop) begin
            tr.out_data  <= frame[FW-1 -: 8];
            sreg         <= frame << 8;
            idx          <= '0;
            tr.out_valid <= 1'b1;
            state        <= SEND;
          end
        end
        SEND: begin
          if (fire) begin
            if (!last) begin
              tr.out_data <= sreg[FW-1 -: 8];
              sreg        <= sreg << 8;
              idx         <= idx + 1'b1;
            end else if (pop) begin
              tr.out_data <= frame[FW-1 -: 8];
              sreg        <= frame << 8;
              idx         <= '0;
            end else begin
              tr.out_valid <= 1'b0;
              state        <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
